// File: rtl/riscv_pkg.sv
// Shared load/store encodings, LSU state, fault causes and the execute-stage request bundle.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } lsu_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE             = 2'b00,
    FAULT_MISALIGNED_LOAD  = 2'b01,
    FAULT_MISALIGNED_STORE = 2'b10,
    FAULT_OUT_OF_RANGE     = 2'b11
  } fault_cause_t;

  typedef struct packed {
    logic            mem_read;
    logic            datamem_wr_enable;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] wr_datamem_data;
    logic [4:0]      rd;
    logic            regfile_wr_enable;
    logic [XLEN-1:0] instr_addr_plus;
    logic [1:0]      result_src;
  } lsu_req_t;

  // Shift the addressed lane down and extend; unlisted encodings read as a full word.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      lane,
                                                  input logic [2:0]      funct3);
    logic [XLEN-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (funct3)
      F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   load_extend = {24'b0, sh[7:0]};
      F3_HU:   load_extend = {16'b0, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/datamem_bytelane_ram.sv
// Word-organised data RAM: one byte-enabled write port, one combinational read port.
module datamem_bytelane_ram #(
  parameter  int unsigned DEPTH_BYTES = 512,
  localparam int unsigned WORDS       = DEPTH_BYTES / 4,
  localparam int unsigned IDX_W       = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stage_memory_lsu.sv
// Memory pipeline stage: byte-lane data RAM with optional wait states, flush handling
// and misaligned / out-of-range fault reporting, plus the writeback passthroughs.
module stage_memory_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_BYTES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            execute_valid,
  input  logic            execute_mem_read,
  input  logic            execute_datamem_wr_enable,
  input  logic [2:0]      execute_funct3,
  input  logic [XLEN-1:0] execute_alu_result,
  input  logic [XLEN-1:0] execute_wr_datamem_data,
  input  logic [4:0]      execute_rd,
  input  logic            execute_regfile_wr_enable,
  input  logic [XLEN-1:0] execute_instr_addr_plus,
  input  logic [1:0]      execute_result_src,
  input  logic            flush,
  output logic            mem_stall,
  output logic            mem_valid,
  output logic [4:0]      mem_rd,
  output logic            mem_regfile_wr_enable,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_instr_addr_plus,
  output logic [1:0]      mem_result_src,
  output logic [XLEN-1:0] mem_rd_datamem_data,
  output logic            mem_fault,
  output logic [1:0]      mem_fault_cause
);

  localparam int unsigned CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  lsu_req_t         req_q;
  lsu_req_t         exec_req;
  lsu_req_t         cur;
  fault_cause_t     cause;

  logic            mem_op, accept, last_wait, complete;
  logic [1:0]      lane;
  logic            is_half, is_word, misaligned, out_of_range;
  logic            ram_we;
  logic [3:0]      ram_be;
  logic [XLEN-1:0] ram_wdata, ram_rdata, load_data;

  assign exec_req = '{mem_read:          execute_mem_read,
                      datamem_wr_enable: execute_datamem_wr_enable,
                      funct3:            execute_funct3,
                      alu_result:        execute_alu_result,
                      wr_datamem_data:   execute_wr_datamem_data,
                      rd:                execute_rd,
                      regfile_wr_enable: execute_regfile_wr_enable,
                      instr_addr_plus:   execute_instr_addr_plus,
                      result_src:        execute_result_src};

  // In IDLE the live execute op is the one being serviced; in WAIT it is the latched one.
  assign cur    = (state == S_IDLE) ? exec_req : req_q;
  assign mem_op = cur.mem_read || cur.datamem_wr_enable;

  assign lane         = cur.alu_result[1:0];
  assign is_half      = (cur.funct3[1:0] == 2'b01);
  assign is_word      = cur.funct3[1];
  assign misaligned   = (is_half && lane[0]) || (is_word && (lane != 2'b00));
  assign out_of_range = |cur.alu_result[XLEN-1:ADDR_W];

  always_comb begin
    cause = FAULT_NONE;
    if (mem_op) begin
      if (out_of_range)    cause = FAULT_OUT_OF_RANGE;
      else if (misaligned) cause = cur.datamem_wr_enable ? FAULT_MISALIGNED_STORE
                                                         : FAULT_MISALIGNED_LOAD;
    end
  end

  assign accept    = (state == S_IDLE) && execute_valid && !flush;
  assign last_wait = (state == S_WAIT) && (cnt == CNT_W'(1)) && !flush;
  assign complete  = (accept && !(mem_op && HAS_WAIT)) || last_wait;

  assign mem_stall = ((state == S_IDLE) && execute_valid && mem_op && HAS_WAIT) ||
                     ((state == S_WAIT) && (cnt > CNT_W'(1)));

  assign ram_we    = rst_n && complete && cur.datamem_wr_enable && (cause == FAULT_NONE);
  assign ram_be    = (is_word ? 4'b1111 : is_half ? 4'b0011 : 4'b0001) << lane;
  assign ram_wdata = cur.wr_datamem_data << {lane, 3'b000};
  assign load_data = (cur.mem_read && (cause == FAULT_NONE))
                     ? load_extend(ram_rdata, lane, cur.funct3) : '0;

  datamem_bytelane_ram #(.DEPTH_BYTES(DEPTH_BYTES)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .waddr (cur.alu_result[ADDR_W-1:2]),
    .wdata (ram_wdata),
    .raddr (cur.alu_result[ADDR_W-1:2]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= S_IDLE;
      cnt                   <= '0;
      req_q                 <= '0;
      mem_valid             <= 1'b0;
      mem_rd                <= '0;
      mem_regfile_wr_enable <= 1'b0;
      mem_alu_result        <= '0;
      mem_instr_addr_plus   <= '0;
      mem_result_src        <= '0;
      mem_rd_datamem_data   <= '0;
      mem_fault             <= 1'b0;
      mem_fault_cause       <= '0;
    end else begin
      mem_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_q <= exec_req;
            if (mem_op && HAS_WAIT) begin
              state <= S_WAIT;
              cnt   <= CNT_W'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          if (flush || (cnt == CNT_W'(1))) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      // Faulted ops still retire, but never write the register file.
      if (complete) begin
        mem_valid             <= 1'b1;
        mem_rd                <= cur.rd;
        mem_regfile_wr_enable <= cur.regfile_wr_enable && (cause == FAULT_NONE);
        mem_alu_result        <= cur.alu_result;
        mem_instr_addr_plus   <= cur.instr_addr_plus;
        mem_result_src        <= cur.result_src;
        mem_rd_datamem_data   <= load_data;
        mem_fault             <= (cause != FAULT_NONE);
        mem_fault_cause       <= cause;
      end
    end
  end

endmodule

// File: doc/stage_memory_lsu.md
Name: stage_memory_lsu

Overview:
Parametrised successor to the single-cycle memory stage. It sits between execute and writeback and keeps the register passthroughs (rd, regfile write enable, ALU result, PC+4, result_src). It adds a parametrised word-organised data RAM with byte lanes, configurable access wait states through a small FSM with a stall to the hazard unit, a valid/flush pipeline handshake, and misalignment / out-of-range fault reporting.

Parameters:
DEPTH_BYTES, 512, data RAM size in bytes; power of two, >= 8
WAIT_STATES, 0, extra cycles per load/store; 0 reproduces single-cycle behaviour
ADDR_W, $clog2(DEPTH_BYTES), byte address bits used for indexing

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  synchronous, active-low reset
execute_valid  in  1  execute stage holds a valid instruction
execute_mem_read  in  1  instruction is a load
execute_datamem_wr_enable  in  1  instruction is a store
execute_funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
execute_alu_result  in  32  effective address / ALU result
execute_wr_datamem_data  in  32  store data, right-aligned
execute_rd  in  5  destination register
execute_regfile_wr_enable  in  1  register write enable
execute_instr_addr_plus  in  32  PC+4
execute_result_src  in  2  writeback mux select
flush  in  1  kill the in-flight and accepted instruction
mem_stall  out  1  hold IF/ID/EX (combinational)
mem_valid  out  1  outputs below carry a retired instruction
mem_rd  out  5  registered passthrough
mem_regfile_wr_enable  out  1  registered; forced 0 on fault
mem_alu_result  out  32  registered passthrough
mem_instr_addr_plus  out  32  registered passthrough
mem_result_src  out  2  registered passthrough
mem_rd_datamem_data  out  32  load data, extended per funct3
mem_fault  out  1  access faulted; valid with mem_valid
mem_fault_cause  out  2  00 none, 01 misaligned load, 10 misaligned store, 11 out of range

Behaviour:
- Reset (rst_n = 0 at an edge): FSM goes to IDLE, counter 0. Every registered output is 0. Any pending store is discarded. RAM contents are not reset.
- RAM: DEPTH_BYTES/4 words × 4 byte lanes. Word index = addr[ADDR_W-1:2]. Lane = addr[1:0].
- Fault check at accept, with priority out-of-range > misaligned:
  - out of range: addr >= DEPTH_BYTES, i.e. any bit above ADDR_W-1 set. There is no wrap.
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - A faulted op performs no write, returns load data 0 and sets mem_regfile_wr_enable=0, but still takes the full access latency.
- States:
  - IDLE: accepts when execute_valid && !flush. The request (all execute_* fields) is latched in a request register.
    - Non-memory op: completes in the same cycle.
    - Memory op with WAIT_STATES=0: completes in the same cycle.
    - Memory op with WAIT_STATES>0: go to WAIT with cnt = WAIT_STATES.
  - WAIT: cnt decrements each cycle. The cycle with cnt==1 is the final cycle; the FSM returns to IDLE after it.
- mem_stall = (IDLE && execute_valid && mem op && WAIT_STATES>0) || (WAIT && cnt>1). It is low in the final cycle, so the next instruction can be accepted on the following edge with no bubble.
- Completion edge (end of the final cycle):
  - Stores commit using byte enables: B = 1 lane, H = 2 lanes, W = 4.
  - The load word is read from the array before that edge's write, then shifted and sign/zero extended into mem_rd_datamem_data.
  - Passthroughs register from the latched request.
  - mem_valid <= 1.
- Latency from accept to mem_valid is WAIT_STATES+1 cycles. mem_valid = 0 in every cycle without a completion (bubbles during stall).
- Ordering: a load accepted after a store sees the stored data, because the store commits at its completion edge, which precedes the load's completion.
- funct3 011/110/111 on a load are treated as W.
- flush (sampled at an edge):
  - Aborts any WAIT op with no write and returns the FSM to IDLE.
  - Blocks acceptance of the current execute op and forces mem_valid <= 0.
  - flush has priority over completion in the same cycle.
- Reset asserted mid-WAIT behaves like flush plus clearing all outputs.

Decomposition:
- Shared package (riscv_pkg):
  - funct3 load/store encodings.
  - FSM state typedef: IDLE, WAIT.
  - fault-cause enum.
  - Request struct bundling the execute_* fields.
- One sub-module, datamem_bytelane_ram:
  - parametrised DEPTH_BYTES.
  - one write port with 4-bit byte enable.
  - one combinational word read port.
- The FSM, fault check, alignment shift and extension stay in the top.

Test Plan:
- WAIT_STATES=0: SW 0xDEADBEEF @0x10, then LW @0x10 → mem_valid each cycle, no stall; load data 0xDEADBEEF.
- LB @0x13 → 0xFFFFFFDE. LBU @0x13 → 0x000000DE. LH @0x12 → 0xFFFFDEAD. LHU @0x12 → 0x0000DEAD.
- WAIT_STATES=2: LW accepted at cycle t → mem_stall high t..t+1, low t+2; mem_valid only at t+3; next instr accepted at edge t+3.
- SH @0x11 → fault 10, mem_regfile_wr_enable 0, RAM @0x10..0x13 unchanged. LW @DEPTH_BYTES → fault 11, data 0.
- WAIT_STATES=2: flush during the first WAIT cycle of SW 0x12345678 @0x20 → no mem_valid; later LW @0x20 returns the prior contents.
- rst_n=0 mid-WAIT → next cycle all outputs 0, mem_stall 0, FSM IDLE, store not committed.
